// File: rtl/vmac_pkg.sv
// Shared types, defaults and saturation helper for the vector MAC engine.
package vmac_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } vmac_state_t;

    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    localparam int VMAC_N_CH    = 4;
    localparam int VMAC_CH_W    = 64;
    localparam int VMAC_ELEM_W  = 8;
    localparam int VMAC_ACC_W   = 32;
    localparam int VMAC_OUT_W   = 16;
    localparam int VMAC_FRAC_SH = 0;

    // Clamp a wide signed value into the signed range of out_w bits.
    function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/vec_mac_engine_if.sv
// Beat input and result output handshake bundle of the vector MAC engine.
interface vec_mac_engine_if #(
    parameter int N_CH  = 4,
    parameter int CH_W  = 64,
    parameter int OUT_W = 16
);
    logic [N_CH*CH_W-1:0] dma_ch;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_W-1:0]     result;
    logic                 result_valid;
    logic                 result_ready;

    modport master (
        output dma_ch, in_valid, result_ready,
        input  in_ready, result, result_valid
    );

    modport slave (
        input  dma_ch, in_valid, result_ready,
        output in_ready, result, result_valid
    );
endinterface

// File: rtl/vmac_lane_reduce.sv
// Combinational per-beat reduction: signed lane MAC (mode 0) or XNOR-popcount (mode 1).
module vmac_lane_reduce
    import vmac_pkg::*;
#(
    parameter int N_CH   = VMAC_N_CH,
    parameter int CH_W   = VMAC_CH_W,
    parameter int ELEM_W = VMAC_ELEM_W,
    parameter int ACC_W  = VMAC_ACC_W
) (
    input  logic                    mode,
    input  logic [N_CH*CH_W-1:0]    dma_ch,
    output logic signed [ACC_W-1:0] partial
);
    localparam int LANES = CH_W / ELEM_W;
    localparam int NP    = N_CH / 2;

    logic [CH_W-1:0]              act;
    logic [CH_W-1:0]              wt;
    logic signed [ELEM_W-1:0]     a_e;
    logic signed [ELEM_W-1:0]     w_e;
    logic signed [2*ELEM_W-1:0]   prod;
    int                           pop;

    // Activation channel p pairs with weight channel p + N_CH/2.
    always_comb begin
        partial = '0;
        act     = '0;
        wt      = '0;
        a_e     = '0;
        w_e     = '0;
        prod    = '0;
        pop     = 0;
        for (int p = 0; p < NP; p++) begin
            act = dma_ch[p*CH_W +: CH_W];
            wt  = dma_ch[(p+NP)*CH_W +: CH_W];
            if (mode == MODE_BIN) begin
                pop     = $countones(~(act ^ wt));
                partial = partial + ACC_W'(2 * pop - CH_W);
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    a_e     = act[l*ELEM_W +: ELEM_W];
                    w_e     = wt[l*ELEM_W +: ELEM_W];
                    prod    = a_e * w_e;
                    partial = partial + ACC_W'(prod);
                end
            end
        end
    end

endmodule

// File: rtl/vec_mac_engine.sv
// Vector MAC engine: streams beats, accumulates, then offers a saturated biased result.
// Optional build macro VMAC_RELU_EN clamps negative results to zero.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting beats until vec_len have been taken
// DRAIN | two cycles letting stage 1 and the accumulator settle
// OUT   | result held valid until result_ready
module vec_mac_engine
    import vmac_pkg::*;
#(
    parameter int N_CH    = VMAC_N_CH,
    parameter int CH_W    = VMAC_CH_W,
    parameter int ELEM_W  = VMAC_ELEM_W,
    parameter int ACC_W   = VMAC_ACC_W,
    parameter int OUT_W   = VMAC_OUT_W,
    parameter int FRAC_SH = VMAC_FRAC_SH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               start,
    input  logic               op_mode,
    input  logic [15:0]        vec_len,
    input  logic [OUT_W-1:0]   bias,
    output logic               busy,
    output logic               done,
    vec_mac_engine_if.slave    bus
);
    vmac_state_t             state;
    logic                    mode_r;
    logic [OUT_W-1:0]        bias_r;
    logic [15:0]             cnt;
    logic                    drain_2nd;
    logic signed [ACC_W-1:0] s1;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] partial;
    logic [OUT_W-1:0]        result_r;
    logic                    rv_r;
    logic                    in_ready_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    fire;

    logic signed [63:0]      acc_ext;
    logic signed [63:0]      bias_ext;
    logic signed [63:0]      sum;
    logic [OUT_W-1:0]        sat_res;
    logic [OUT_W-1:0]        res_next;

    vmac_lane_reduce #(
        .N_CH   (N_CH),
        .CH_W   (CH_W),
        .ELEM_W (ELEM_W),
        .ACC_W  (ACC_W)
    ) u_reduce (
        .mode    (mode_r),
        .dma_ch  (bus.dma_ch),
        .partial (partial)
    );

    assign fire = bus.in_valid && in_ready_r;

    // Widen before shift and bias add so the sum itself can never wrap.
    assign acc_ext  = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    assign bias_ext = {{(64-OUT_W){bias_r[OUT_W-1]}}, bias_r};
    assign sum      = (acc_ext >>> FRAC_SH) + bias_ext;
    assign sat_res  = OUT_W'(sat_fn(sum, OUT_W));

`ifdef VMAC_RELU_EN
    assign res_next = sat_res[OUT_W-1] ? '0 : sat_res;
`else
    assign res_next = sat_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_r     <= MODE_INT;
            bias_r     <= '0;
            cnt        <= '0;
            drain_2nd  <= 1'b0;
            s1         <= '0;
            acc        <= '0;
            result_r   <= '0;
            rv_r       <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            s1     <= fire ? partial : '0;
            if (state != S_IDLE)
                acc <= acc + s1;
            if (clr) begin
                state      <= S_IDLE;
                cnt        <= '0;
                s1         <= '0;
                acc        <= '0;
                rv_r       <= 1'b0;
                in_ready_r <= 1'b0;
                busy_r     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            mode_r    <= op_mode;
                            bias_r    <= bias;
                            acc       <= '0;
                            cnt       <= vec_len;
                            drain_2nd <= 1'b0;
                            busy_r    <= 1'b1;
                            if (vec_len == 16'd0) begin
                                state <= S_DRAIN;
                            end else begin
                                state      <= S_RUN;
                                in_ready_r <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (fire) begin
                            cnt <= cnt - 16'd1;
                            if (cnt == 16'd1) begin
                                state      <= S_DRAIN;
                                in_ready_r <= 1'b0;
                                drain_2nd  <= 1'b0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        drain_2nd <= 1'b1;
                        if (drain_2nd) begin
                            state    <= S_OUT;
                            result_r <= res_next;
                            rv_r     <= 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (bus.result_ready) begin
                            state  <= S_IDLE;
                            rv_r   <= 1'b0;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.result       = result_r;
    assign bus.result_valid = rv_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_vec_mac_engine.sv
// Directed self-checking bench for vec_mac_engine with an arithmetic reference model.
module tb_vec_mac_engine;
    localparam int N_CH = 4, CH_W = 64, OUT_W = 16, FRAC_SH = 0;
    localparam int BW = N_CH * CH_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0, start = 1'b0, op_mode = 1'b0;
    logic [15:0] vec_len = '0;
    logic [OUT_W-1:0] bias = '0;
    logic busy, done;

    vec_mac_engine_if #(.N_CH(N_CH), .CH_W(CH_W), .OUT_W(OUT_W)) bus ();

    vec_mac_engine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .start   (start),
        .op_mode (op_mode),
        .vec_len (vec_len),
        .bias    (bias),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit in_ready_seen = 0;
    logic [OUT_W-1:0] exp_result = '0;
    logic [BW-1:0] beats[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: element-wise arithmetic and bitwise +1/-1 agreement counting.
    function automatic int beat_val(input bit mode, input logic [BW-1:0] v);
        int s = 0;
        logic [CH_W-1:0] a, w;
        for (int p = 0; p < N_CH/2; p++) begin
            a = v[p*CH_W +: CH_W];
            w = v[(p+N_CH/2)*CH_W +: CH_W];
            for (int l = 0; l < CH_W/8; l++) begin
                if (!mode) s += int'($signed(a[l*8 +: 8])) * int'($signed(w[l*8 +: 8]));
            end
            if (mode)
                for (int b = 0; b < CH_W; b++) s += (a[b] == w[b]) ? 1 : -1;
        end
        return s;
    endfunction

    function automatic logic [OUT_W-1:0] model_job(input bit mode, input int len, input int b);
        int acc = 0;
        longint r;
        for (int j = 0; j < len; j++) acc += beat_val(mode, beats[j]);
        r = longint'(acc >>> FRAC_SH) + b;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef VMAC_RELU_EN
        if (r < 0) r = 0;
`endif
        return OUT_W'(r);
    endfunction

    task automatic fill(input logic [7:0] a, input logic [7:0] w, input int n);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back({{16{w}}, {16{a}}});
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.result_valid) chk("result_vs_model", 32'(bus.result), 32'(exp_result));
            if (bus.in_ready) begin
                in_ready_seen = 1;
                chk("in_ready_implies_busy", 32'(busy), 32'd1);
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_job(input bit mode, input int len, input int b, input bit gaps,
                           input int rdy_delay, input bit has_lit, input logic [OUT_W-1:0] lit);
        int k = 0, got = 0, guard = 0, d0;
        logic [OUT_W-1:0] held;
        exp_result = model_job(mode, len, b);
        if (has_lit) chk("model_literal", 32'(exp_result), 32'(lit));
        d0 = done_cnt;
        in_ready_seen = 0;
        @(posedge clk); #1;
        op_mode = mode; vec_len = 16'(len); bias = OUT_W'(b); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (gaps) begin start = 1'b1; vec_len = 16'd1; end
        while (got < len && guard < 200) begin
            bus.in_valid = gaps ? (guard % 2 == 1) : 1'b1;
            bus.dma_ch   = beats[got];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin k = cyc; got++; end
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        if (got < len) chk("beat_timeout", 32'(got), 32'(len));
        guard = 0;
        at_neg();
        while (!bus.result_valid && guard < 50) begin at_neg(); guard++; end
        chk("result_valid_seen", 32'(bus.result_valid), 32'd1);
        if (len > 0) chk("latency_k_plus_3", 32'(cyc - k), 32'd3);
        chk("result_literal", 32'(bus.result), 32'(exp_result));
        held = bus.result;
        for (int i = 0; i < rdy_delay; i++) begin
            at_neg();
            chk("held_result", 32'(bus.result), 32'(held));
            chk("held_valid", 32'(bus.result_valid), 32'd1);
            chk("no_early_done", 32'(done_cnt), 32'(d0));
        end
        @(posedge clk); #1;
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        at_neg();
        chk("valid_drop", 32'(bus.result_valid), 32'd0);
        at_neg();
        chk("done_one_pulse", 32'(done_cnt), 32'(d0 + 1));
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        bus.in_valid = 1'b0;
        bus.dma_ch = '0;
        bus.result_ready = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        #10 rst_n = 1'b1;

        fill(8'hAA, 8'hAA, 3);
        run_job(1'b1, 3, 0, 1'b0, 0, 1'b1, 16'h0180);

        fill(8'h02, 8'h03, 4);
        run_job(1'b0, 4, 16, 1'b0, 0, 1'b1, 16'd400);

        fill(8'h7F, 8'h7F, 1);
        run_job(1'b0, 1, 0, 1'b0, 0, 1'b1, 16'h7FFF);

        fill(8'h7F, 8'h80, 1);
`ifdef VMAC_RELU_EN
        run_job(1'b0, 1, 0, 1'b0, 0, 1'b1, 16'h0000);
`else
        run_job(1'b0, 1, 0, 1'b0, 0, 1'b1, 16'h8000);
`endif

        fill(8'hAA, 8'hAA, 3);
        run_job(1'b1, 3, 0, 1'b1, 5, 1'b1, 16'd384);

        // Mixed-value beats checked against the model only.
        beats.delete();
        for (int i = 0; i < 5; i++)
            beats.push_back({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        run_job(1'b0, 5, -300, 1'b0, 2, 1'b0, 16'h0);

        // Abort after two of three beats.
        fill(8'hAA, 8'hAA, 3);
        d0 = done_cnt;
        @(posedge clk); #1;
        op_mode = 1'b1; vec_len = 16'd3; bias = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1; bus.dma_ch = beats[0];
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        at_neg();
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (5) at_neg();
        chk("clr_no_valid", 32'(bus.result_valid), 32'd0);
        chk("clr_no_done", 32'(done_cnt), 32'(d0));

        @(posedge clk); #1;
        start = 1'b1; clr = 1'b1; vec_len = 16'd1;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        at_neg();
        chk("clr_beats_start", 32'(busy), 32'd0);

        fill(8'hAA, 8'hAA, 1);
        run_job(1'b1, 1, 0, 1'b0, 0, 1'b1, 16'd128);

        beats.delete();
`ifdef VMAC_RELU_EN
        run_job(1'b0, 0, -5, 1'b0, 0, 1'b1, 16'h0000);
`else
        run_job(1'b0, 0, -5, 1'b0, 0, 1'b1, 16'hFFFB);
`endif
        chk("len0_no_in_ready", 32'(in_ready_seen), 32'd0);

        // Reset in the middle of a job aborts without done.
        fill(8'h01, 8'h01, 4);
        d0 = done_cnt;
        @(posedge clk); #1;
        op_mode = 1'b0; vec_len = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1; bus.dma_ch = beats[0];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) at_neg();
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        chk("midrst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
